// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 definitions: sizes, round constants and the small sigma functions
// used by the message schedule and the rest of the engine.
package sha256_msg_schedule_pkg;

    localparam int WORDSIZE   = 32;
    localparam int BLOCK_BITS = 512;
    localparam int SCHED_WIN  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (WORDSIZE - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / word-out bundle between the padder, the message schedule and the round stage.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never drops
// without a transfer (except abort/reset), and data is held stable while valid && !ready.
interface sha256_msg_schedule_if;
    import sha256_msg_schedule_pkg::*;

    logic                  blk_valid;
    logic                  blk_ready;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  abort;
    logic                  w_valid;
    logic                  w_ready;
    logic [WORDSIZE-1:0]   Wj;
    logic [WORDSIZE-1:0]   Kj;
    logic [5:0]            j;
    logic                  w_last;

    modport master (
        output blk_valid, blk_data, abort, w_ready,
        input  blk_ready, w_valid, Wj, Kj, j, w_last
    );

    modport slave (
        input  blk_valid, blk_data, abort, w_ready,
        output blk_ready, w_valid, Wj, Kj, j, w_last
    );

endinterface

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: next W from the four window taps.
module sha256_w_expand
    import sha256_msg_schedule_pkg::*;
(
    input  logic [WORDSIZE-1:0] w0,
    input  logic [WORDSIZE-1:0] w1,
    input  logic [WORDSIZE-1:0] w9,
    input  logic [WORDSIZE-1:0] w14,
    output logic [WORDSIZE-1:0] w_next
);

    // Modular add; the carry out of bit 31 is dropped by the 32-bit result.
    assign w_next = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts a padded block and streams (Wj, Kj) pairs
// to the round stage using a 16-word sliding window.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    sha256_msg_schedule_if.slave    bus,
    output sched_state_e            dbg_state
);

    localparam logic [5:0] LAST_J = 6'(ROUNDS - 1);

    sched_state_e        state_q, state_d;
    logic [5:0]          j_q, j_d;
    logic [WORDSIZE-1:0] wreg [SCHED_WIN];
    logic [WORDSIZE-1:0] w_next;
    logic                load, shift, rdy, vld;

    sha256_w_expand u_expand (
        .w0     (wreg[0]),
        .w1     (wreg[1]),
        .w9     (wreg[9]),
        .w14    (wreg[14]),
        .w_next (w_next)
    );

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        load    = 1'b0;
        shift   = 1'b0;
        rdy     = 1'b0;
        vld     = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = !bus.abort;
                if (bus.blk_valid && !bus.abort) begin
                    load    = 1'b1;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                vld = 1'b1;
                // Abort wins over a same-cycle transfer.
                if (bus.abort) begin
                    state_d = IDLE;
                    j_d     = '0;
                end else if (bus.w_ready) begin
                    if (j_q == LAST_J) begin
                        state_d = IDLE;
                        j_d     = '0;
                    end else begin
                        shift = 1'b1;
                        j_d   = j_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            for (int i = 0; i < SCHED_WIN; i++) wreg[i] <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            if (load) begin
                for (int i = 0; i < SCHED_WIN; i++)
                    wreg[i] <= bus.blk_data[BLOCK_BITS-1-WORDSIZE*i -: WORDSIZE];
            end else if (shift) begin
                for (int i = 0; i < SCHED_WIN-1; i++) wreg[i] <= wreg[i+1];
                wreg[SCHED_WIN-1] <= w_next;
            end
        end
    end

    assign bus.blk_ready = rdy;
    assign bus.w_valid   = vld;
    assign bus.Wj        = wreg[0];
    assign bus.Kj        = K[j_q];
    assign bus.j         = j_q;
    assign bus.w_last    = (state_q == RUN) && (j_q == LAST_J);
    assign dbg_state     = state_q;

endmodule
